// File: rtl/move_scheduler.sv
// move_scheduler: paces snake moves, captures direction and offers head steps.
// Define MOVE_SCHED_WRAP_EN to make the walls wrap instead of crashing.
module move_scheduler #(
    parameter int GRID_W    = 8,
    parameter int GRID_H    = 8,
    parameter int COORD_W   = 3,
    parameter int TICK_EASY = 25_000_000,
    parameter int TICK_MED  = 12_500_000,
    parameter int TICK_HARD = 6_250_000,
    parameter int START_X   = 2,
    parameter int START_Y   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [1:0]         difficulty,
    input  logic               up_button,
    input  logic               right_button,
    input  logic               down_button,
    input  logic               left_button,
    input  logic [COORD_W-1:0] food_x,
    input  logic [COORD_W-1:0] food_y,
    output logic               step_valid,
    input  logic               step_ready,
    output logic [COORD_W-1:0] step_x,
    output logic [COORD_W-1:0] step_y,
    output logic               step_grow,
    output logic [COORD_W-1:0] head_x,
    output logic [COORD_W-1:0] head_y,
    output logic [1:0]         dir,
    output logic               crashed
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        COMPUTE,
        ISSUE,
        CRASH
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [COORD_W:0]   ONE    = (COORD_W+1)'(1);
    localparam logic [COORD_W:0]   X_LIM  = (COORD_W+1)'(GRID_W);
    localparam logic [COORD_W:0]   Y_LIM  = (COORD_W+1)'(GRID_H);
    localparam logic [COORD_W-1:0] X_INIT = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] Y_INIT = COORD_W'(START_Y);
`ifdef MOVE_SCHED_WRAP_EN
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(GRID_H - 1);
`endif

    state_t             state_q, state_d;
    logic [31:0]        period_q, period_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [COORD_W-1:0] head_x_q, head_x_d;
    logic [COORD_W-1:0] head_y_q, head_y_d;
    logic [COORD_W-1:0] step_x_q, step_x_d;
    logic [COORD_W-1:0] step_y_q, step_y_d;
    logic [1:0]         dir_q, dir_d;
    logic [1:0]         pend_q, pend_d;
    logic               valid_q, valid_d;
    logic               grow_q, grow_d;
    logic               crash_q, crash_d;

    logic [COORD_W:0]   hx_w, hy_w;
    logic [COORD_W:0]   cx_w, cy_w;
    logic               at_edge;
    logic               collide;
    logic [COORD_W-1:0] cand_x, cand_y;
    logic [1:0]         btn_dir;
    logic               btn_any;
    logic               take_btn;
    logic [31:0]        tick_sel;

    assign hx_w = {1'b0, head_x_q};
    assign hy_w = {1'b0, head_y_q};

    // One extra bit exposes underflow on the low walls and GRID_* on the high walls.
    always_comb begin
        cx_w    = hx_w;
        cy_w    = hy_w;
        at_edge = 1'b0;
        unique case (pend_q)
            DIR_UP: begin
                cy_w    = hy_w - ONE;
                at_edge = cy_w[COORD_W];
            end
            DIR_RIGHT: begin
                cx_w    = hx_w + ONE;
                at_edge = (cx_w == X_LIM);
            end
            DIR_DOWN: begin
                cy_w    = hy_w + ONE;
                at_edge = (cy_w == Y_LIM);
            end
            DIR_LEFT: begin
                cx_w    = hx_w - ONE;
                at_edge = cx_w[COORD_W];
            end
        endcase
    end

    always_comb begin
        cand_x  = cx_w[COORD_W-1:0];
        cand_y  = cy_w[COORD_W-1:0];
        collide = 1'b0;
`ifdef MOVE_SCHED_WRAP_EN
        if (at_edge) begin
            unique case (pend_q)
                DIR_UP:    cand_y = Y_LAST;
                DIR_RIGHT: cand_x = '0;
                DIR_DOWN:  cand_y = '0;
                DIR_LEFT:  cand_x = X_LAST;
            endcase
        end
`else
        collide = at_edge;
`endif
    end

    always_comb begin
        btn_any = 1'b1;
        btn_dir = DIR_UP;
        if (up_button) begin
            btn_dir = DIR_UP;
        end else if (right_button) begin
            btn_dir = DIR_RIGHT;
        end else if (down_button) begin
            btn_dir = DIR_DOWN;
        end else if (left_button) begin
            btn_dir = DIR_LEFT;
        end else begin
            btn_any = 1'b0;
        end
    end

    // Reversing straight into the neck is never allowed.
    assign take_btn = btn_any
                   && (btn_dir != (dir_q ^ 2'b10))
                   && (state_q != CRASH);

    always_comb begin
        tick_sel = 32'(TICK_EASY);
        unique case (difficulty)
            2'b10:   tick_sel = 32'(TICK_MED);
            2'b11:   tick_sel = 32'(TICK_HARD);
            default: tick_sel = 32'(TICK_EASY);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        step_x_d = step_x_q;
        step_y_d = step_y_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        valid_d  = valid_q;
        grow_d   = grow_q;
        crash_d  = crash_q;

        if (take_btn) begin
            pend_d = btn_dir;
        end

        unique case (state_q)
            IDLE: begin
                if (enable && (difficulty != 2'b00)) begin
                    state_d  = WAIT_TICK;
                    period_d = tick_sel;
                    cnt_d    = '0;
                end
            end
            WAIT_TICK: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == period_q - 32'd1) begin
                    state_d = COMPUTE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            COMPUTE: begin
                dir_d = pend_q;
                if (collide) begin
                    state_d = CRASH;
                    crash_d = 1'b1;
                end else begin
                    state_d  = ISSUE;
                    valid_d  = 1'b1;
                    step_x_d = cand_x;
                    step_y_d = cand_y;
                    grow_d   = (cand_x == food_x) && (cand_y == food_y);
                end
            end
            ISSUE: begin
                if (step_ready) begin
                    valid_d  = 1'b0;
                    head_x_d = step_x_q;
                    head_y_d = step_y_q;
                    cnt_d    = '0;
                    state_d  = enable ? WAIT_TICK : IDLE;
                end
            end
            CRASH: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            period_q <= 32'(TICK_EASY);
            cnt_q    <= '0;
            head_x_q <= X_INIT;
            head_y_q <= Y_INIT;
            step_x_q <= '0;
            step_y_q <= '0;
            dir_q    <= DIR_RIGHT;
            pend_q   <= DIR_RIGHT;
            valid_q  <= 1'b0;
            grow_q   <= 1'b0;
            crash_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            step_x_q <= step_x_d;
            step_y_q <= step_y_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            valid_q  <= valid_d;
            grow_q   <= grow_d;
            crash_q  <= crash_d;
        end
    end

    assign step_valid = valid_q;
    assign step_x     = step_x_q;
    assign step_y     = step_y_q;
    assign step_grow  = grow_q;
    assign head_x     = head_x_q;
    assign head_y     = head_y_q;
    assign dir        = dir_q;
    assign crashed    = crash_q;

endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: directed and random moves against a grid-level model.
`timescale 1ns/1ps
module tb_move_scheduler;

    localparam int CW = 3;
    localparam int GW = 8;
    localparam int GH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    difficulty = 2'b00;
    logic          up_button = 1'b0;
    logic          right_button = 1'b0;
    logic          down_button = 1'b0;
    logic          left_button = 1'b0;
    logic [CW-1:0] food_x = 3'd6;
    logic [CW-1:0] food_y = 3'd0;
    logic          step_valid;
    logic          step_ready = 1'b1;
    logic [CW-1:0] step_x, step_y;
    logic          step_grow;
    logic [CW-1:0] head_x, head_y;
    logic [1:0]    dir;
    logic          crashed;

    move_scheduler #(
        .GRID_W(GW), .GRID_H(GH), .COORD_W(CW),
        .TICK_EASY(4), .TICK_MED(3), .TICK_HARD(2),
        .START_X(2), .START_Y(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .difficulty(difficulty),
        .up_button(up_button), .right_button(right_button),
        .down_button(down_button), .left_button(left_button),
        .food_x(food_x), .food_y(food_y),
        .step_valid(step_valid), .step_ready(step_ready),
        .step_x(step_x), .step_y(step_y), .step_grow(step_grow),
        .head_x(head_x), .head_y(head_y), .dir(dir), .crashed(crashed)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int edges = 0;
    int mx, my, mdir, mpend, mper;
    bit mcrash;

    task automatic cyc();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void next_pos(input int x, input int y, input int d,
                                     output int nx, output int ny,
                                     output bit coll);
        nx = x;
        ny = y;
        case (d)
            0: ny = y - 1;
            1: nx = x + 1;
            2: ny = y + 1;
            default: nx = x - 1;
        endcase
        coll = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`ifdef MOVE_SCHED_WRAP_EN
        coll = 1'b0;
        nx = (nx + GW) % GW;
        ny = (ny + GH) % GH;
`endif
    endfunction

    task automatic model_reset();
        mx = 2; my = 4; mdir = 1; mpend = 1; mcrash = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        difficulty = 2'b00;
        step_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b1;
        model_reset();
    endtask

    task automatic start(input int d);
        difficulty = 2'(d);
        mper = (d == 1) ? 4 : (d == 2) ? 3 : 2;
    endtask

    task automatic press(input bit u, input bit r, input bit d, input bit l);
        int b;
        up_button = u; right_button = r; down_button = d; left_button = l;
        cyc();
        up_button = 0; right_button = 0; down_button = 0; left_button = 0;
        b = u ? 0 : r ? 1 : d ? 2 : l ? 3 : -1;
        if (b >= 0 && b != (mdir ^ 2)) mpend = b;
    endtask

    task automatic run_step(input int t0, input int lat, input int stall,
                            input bit rst_mid);
        int nx, ny;
        bit coll;
        while (!(step_valid || crashed) && (edges - t0) < 40) cyc();
        chk("latency", edges - t0, lat);
        mdir = mpend;
        next_pos(mx, my, mdir, nx, ny, coll);
        if (coll) begin
            chk("crash_flag", crashed, 1);
            chk("crash_novalid", step_valid, 0);
            chk("crash_hx", head_x, mx);
            chk("crash_hy", head_y, my);
            mcrash = 1'b1;
            return;
        end
        chk("valid", step_valid, 1);
        chk("no_crash", crashed, 0);
        chk("step_x", step_x, nx);
        chk("step_y", step_y, ny);
        chk("grow", step_grow, (nx == int'(food_x)) && (ny == int'(food_y)));
        chk("dir", dir, mdir);
        chk("pre_hx", head_x, mx);
        if (rst_mid) begin
            step_ready = 1'b0;
            rst = 1'b0;
            difficulty = 2'b00;
            cyc();
            chk("rstmid_valid", step_valid, 0);
            chk("rstmid_hx", head_x, 2);
            chk("rstmid_hy", head_y, 4);
            chk("rstmid_dir", dir, 1);
            rst = 1'b1;
            step_ready = 1'b1;
            model_reset();
            return;
        end
        if (stall > 0) begin
            step_ready = 1'b0;
            repeat (stall) begin
                cyc();
                chk("hold_valid", step_valid, 1);
                chk("hold_x", step_x, nx);
                chk("hold_y", step_y, ny);
                chk("hold_hx", head_x, mx);
                chk("hold_hy", head_y, my);
            end
            step_ready = 1'b1;
        end
        cyc();
        chk("post_valid", step_valid, 0);
        chk("head_x", head_x, nx);
        chk("head_y", head_y, ny);
        mx = nx;
        my = ny;
    endtask

    task automatic go(input bit u, input bit r, input bit d, input bit l,
                      input int stall, input int lat, input bit scr);
        int t0;
        t0 = edges;
        press(u, r, d, l);
        if (scr) difficulty = 2'($urandom);
        run_step(t0, lat, stall, 1'b0);
    endtask

    initial begin
        int nv;
        int t0;
        logic [31:0] b;
        bit first;

        do_reset();
        chk("rst_hx", head_x, 2);
        chk("rst_hy", head_y, 4);
        chk("rst_dir", dir, 1);
        chk("rst_valid", step_valid, 0);
        chk("rst_crash", crashed, 0);

        enable = 1'b1;
        nv = 0;
        repeat (10) begin
            cyc();
            if (step_valid) nv++;
        end
        chk("unset_valids", nv, 0);

        start(1);
        go(0, 0, 0, 0, 0, 6, 0);
        chk("first_hx", head_x, 3);
        chk("first_hy", head_y, 4);
        go(0, 0, 0, 0, 0, 5, 0);

        go(0, 0, 0, 1, 0, 5, 0);
        chk("rev_hx", head_x, 5);
        go(1, 0, 0, 1, 0, 5, 0);
        chk("prio_hy", head_y, 3);
        chk("prio_dir", dir, 0);

        go(0, 0, 0, 0, 7, 5, 0);
        go(0, 0, 0, 0, 0, 5, 0);

        do_reset();
        start(1);
        go(0, 0, 0, 0, 0, 6, 0);
        for (int i = 0; i < 5; i++) go(0, 0, 0, 0, 0, 5, 0);
        if (mcrash) begin
            repeat (6) cyc();
            chk("crash_hold", crashed, 1);
            chk("crash_hold_valid", step_valid, 0);
            chk("crash_frozen_x", head_x, 7);
            do_reset();
            chk("crash_cleared", crashed, 0);
        end else begin
            chk("wrap_x", head_x, 0);
            chk("wrap_nocrash", crashed, 0);
        end

        do_reset();
        food_x = 3'd3;
        food_y = 3'd4;
        start(2);
        t0 = edges;
        press(0, 0, 0, 0);
        run_step(t0, mper + 2, 0, 1'b1);

        for (int r = 0; r < 30; r++) begin
            do_reset();
            food_x = CW'($urandom_range(0, GW - 1));
            food_y = CW'($urandom_range(0, GH - 1));
            start($urandom_range(1, 3));
            first = 1'b1;
            for (int s = 0; s < 15 && !mcrash; s++) begin
                b = $urandom;
                go(b[1:0] == 0, b[3:2] == 0, b[5:4] == 0, b[7:6] == 0,
                   int'(b[9:8] % 3), first ? mper + 2 : mper + 1, 1'b1);
                first = 1'b0;
            end
            if (mcrash) begin
                repeat (3) cyc();
                chk("rnd_crash_hold", crashed, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
